// File: rtl/mul8x8_seq_if.sv
// Request/result bundle between a client and the sequential multiplier.
// Handshake: the client raises start with a/b for one cycle; it is accepted only when busy is low, and the result arrives later as a one-cycle done pulse alongside product.
interface mul8x8_seq_if #(parameter int N = 8);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul8x8_seq.sv
// Shift-and-add unsigned multiplier controller; the 2N-bit adder lives outside and
// is driven through add_in1/add_in2, its sum returning combinationally on add_out.
module mul8x8_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mul8x8_seq_if.slave    bus,
  output logic [2*N-1:0] add_in1,
  output logic [2*N-1:0] add_in2,
  input  logic [2*N-1:0] add_out,
  output logic           dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    add_in1   = '0;
    add_in2   = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = {{N{1'b0}}, bus.a};
          mplier_d = bus.b;
          cnt_d    = '0;
          state_d  = RUN;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        // Partial product for this bit is gated by the multiplier LSB.
        add_in1  = acc_q;
        add_in2  = mplier_q[0] ? mcand_q : '0;
        acc_d    = add_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          product_d = add_out;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mul8x8_seq.sv
// Self-checking bench for mul8x8_seq with an external adder model and a product scoreboard.
module tb_mul8x8_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] add_in1, add_in2, add_out;
  logic        dbg_state;
  int          cyc;
  int          n_cmp, n_err;
  int          done_seen;

  logic [15:0] exp_q[$];
  int          start_cyc_q[$];

  mul8x8_seq_if #(.N(8)) mif ();

  mul8x8_seq #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (mif.slave),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .add_out   (add_out),
    .dbg_state (dbg_state)
  );

  // 16-bit combinational adder stage
  assign add_out = add_in1 + add_in2;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // scoreboard: every done pulse retires the oldest expected product
  always @(negedge clk) begin
    if (rst_n && mif.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        check("product", {16'd0, mif.product}, {16'd0, exp_q.pop_front()});
        check("latency", 32'(cyc - start_cyc_q.pop_front()), 32'd8);
        check("busy_at_done", {31'd0, mif.busy}, 32'd0);
      end
    end
  end

  // driver: one-cycle start pulse, sampled at the next rising edge
  task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv, input bit accept);
    mif.start = 1'b1;
    mif.a     = av;
    mif.b     = bv;
    @(posedge clk);
    #1;
    if (accept) begin
      exp_q.push_back(16'(av) * 16'(bv));
      start_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    mif.start = 1'b0;
    mif.a     = 8'($urandom_range(0, 255));
    mif.b     = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      start_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic mul_with_trace(input logic [7:0] av, input logic [7:0] bv);
    logic [15:0] part, e2;
    pulse_start(av, bv, 1'b1);
    part = '0;
    for (int i = 0; i < 8; i++) begin
      e2 = bv[i] ? (16'(av) << i) : 16'd0;
      check("busy_run", {31'd0, mif.busy}, 32'd1);
      check("add_in2", {16'd0, add_in2}, {16'd0, e2});
      check("add_in1", {16'd0, add_in1}, {16'd0, part});
      part = part + e2;
      @(negedge clk);
    end
  endtask

  initial begin
    int d0, k;
    cyc = 0; n_cmp = 0; n_err = 0; done_seen = 0;
    mif.start = 1'b0; mif.a = '0; mif.b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_done", {31'd0, mif.done}, 32'd0);
    check("rst_product", {16'd0, mif.product}, 32'd0);
    check("rst_add_in1", {16'd0, add_in1}, 32'd0);
    check("rst_add_in2", {16'd0, add_in2}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic multiply with add_in trace, then boundaries
    mul_with_trace(8'd13, 8'd11);
    wait_drain();
    check("idle_add_in2", {16'd0, add_in2}, 32'd0);
    mul_with_trace(8'd255, 8'd255);
    wait_drain();
    pulse_start(8'd0, 8'd200, 1'b1);
    wait_drain();
    pulse_start(8'd1, 8'd1, 1'b1);
    wait_drain();

    // start while busy is ignored: single done, busy not extended
    d0 = done_seen;
    pulse_start(8'd3, 8'd5, 1'b1);
    @(negedge clk);
    pulse_start(8'd7, 8'd7, 1'b0);
    wait_drain();
    repeat (12) @(negedge clk);
    check("single_done", 32'(done_seen - d0), 32'd1);
    check("product_held", {16'd0, mif.product}, 32'd15);

    // back-to-back: second start lands in the done cycle
    d0 = done_seen;
    pulse_start(8'd6, 8'd7, 1'b1);
    k = 0;
    while (!mif.done && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", {31'd0, mif.done}, 32'd1);
    pulse_start(8'd9, 8'd9, 1'b1);
    check("b2b_busy", {31'd0, mif.busy}, 32'd1);
    wait_drain();
    check("b2b_count", 32'(done_seen - d0), 32'd2);

    // random operands
    for (int i = 0; i < 6; i++) begin
      pulse_start(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
      wait_drain();
    end

    // reset mid-operation
    pulse_start(8'd100, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", {31'd0, mif.busy}, 32'd0);
    check("async_done", {31'd0, mif.done}, 32'd0);
    check("async_product", {16'd0, mif.product}, 32'd0);
    check("async_state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_seen;
    pulse_start(8'd2, 8'd3, 1'b1);
    wait_drain();
    check("post_rst_count", 32'(done_seen - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
